sa_tile_sequencer: RTL and testbench
====================================

SA_TILE_SEQUENCER -- requirements
Module: sa_tile_sequencer

Interface
REQ-001 SHALL have parameter ROWS, default 8: array rows and A-stream lanes.
REQ-002 SHALL have parameter COLS, default 8: array columns and W-stream lanes.
REQ-003 SHALL have parameter INWIDTH, default 8: bits per A/W element.
REQ-004 SHALL have parameter KW, default 16: width of the accumulation-length config.
REQ-005 SHALL have ports as follows: clk  input  1  sole clock, all state on rising edge.
REQ-006 rstn  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  begin one tile; sampled only in IDLE.
REQ-008 abort  input  1  synchronous abort; highest priority after reset.
REQ-009 cfg_k  input  KW  accumulation length K (input vectors per tile), sampled on accepted start.
REQ-010 in_valid  input  1  / in_ready  output  1  — input vector handshake.
REQ-011 a_in  input  INWIDTH x ROWS  /  w_in  input  INWIDTH x COLS  — unskewed input vectors.
REQ-012 a_skew  output  INWIDTH x ROWS  /  w_skew  output  INWIDTH x COLS  — skewed streams to array.
REQ-013 arr_fire  output  1  array advance enable, aligned with a_skew/w_skew.
REQ-014 acc_clr  output  1  one-cycle accumulator clear pulse.
REQ-015 out_valid  output  1  / out_ready  input  1  / drain_col  output  $clog2(COLS) (min 1) — column drain handshake.
REQ-016 done  output  1  one-cycle tile-complete pulse; err  output  1  one-cycle bad-config pulse; busy  output  1  state != IDLE.

Function
REQ-017 SHALL implement states IDLE, LOAD, FLUSH, DRAIN.
REQ-018 IDLE: start=1 with cfg_k!=0 -> LOAD, latch cfg_k, pulse acc_clr the same edge; start=1 with cfg_k==0 -> stay IDLE, pulse err; no acc_clr.
REQ-019 LOAD: in_ready=1; accept = in_valid & in_ready; internal fire = accept; after the K-th accept -> FLUSH.
REQ-020 in_valid low in LOAD SHALL stall: fire=0, skew chains and arr_fire hold, no counter advance.
REQ-021 FLUSH: in_ready=0, fire=1 every cycle for exactly ROWS+COLS-1 cycles, injecting zeros; then -> DRAIN.
REQ-022 Skew: lane r of A (lane c of W) SHALL be an (r+1)-stage ((c+1)-stage) register chain enabled by fire; stage 0 loads a_in[r] on accept, 0 in FLUSH; a_skew[r] = last stage.
REQ-023 arr_fire SHALL equal fire delayed one clock; it aligns with data leaving stage 0.
REQ-024 DRAIN SHALL start with arr_fire=0 (one gap cycle after FLUSH); out_valid=1, drain_col starts at 0, increments on out_valid & out_ready.
REQ-025 Transfer with drain_col==COLS-1 -> IDLE and pulse done the same edge; out_valid drops next cycle.
REQ-026 out_ready low SHALL hold drain_col and out_valid indefinitely.
REQ-027 K counter SHALL be KW bits, count accepts 1..K, no wrap; K=2^KW-1 SHALL be legal.
REQ-028 start while busy SHALL be ignored (no err, no latch).
REQ-029 abort in any state -> IDLE next edge; all skew stages zeroed, counters cleared, arr_fire=0, no done pulse; abort and start together -> abort wins.
REQ-030 in_valid in IDLE/FLUSH/DRAIN SHALL be ignored (in_ready=0).

Reset
REQ-031 rstn=0 SHALL immediately force IDLE, all skew stages 0, counters 0, and outputs in_ready, arr_fire, acc_clr, out_valid, done, err, busy = 0, drain_col=0.
REQ-032 Reset asserted mid-LOAD/FLUSH/DRAIN SHALL abandon the tile; first start after rstn rises SHALL behave as from power-up.

Verification
REQ-033 ROWS=COLS=4, K=3, in_valid always 1, vectors a=1,2,3 -> acc_clr 1 cycle, 3 accepts, 7 FLUSH cycles, a_skew[3] shows 1,2,3 on arr_fire cycles 4,5,6 after first accept, zeros otherwise.
REQ-034 Same with in_valid low 2 cycles after first accept -> arr_fire gap of 2 cycles, skew outputs frozen, total arr_fire-high count still 3+7=10.
REQ-035 DRAIN with out_ready pattern 1,0,0,1,1,1 -> drain_col 0,1,1,1,2,3; done pulses on the edge with drain_col==3 transfer; busy falls same edge.
REQ-036 start with cfg_k=0 -> err pulse 1 cycle, busy stays 0, no acc_clr; start during LOAD -> no effect.
REQ-037 abort in FLUSH cycle 2 -> IDLE next cycle, all a_skew/w_skew = 0, no done; following tile K=1 completes normally.
REQ-038 rstn low for one cycle mid-DRAIN (drain_col=2) -> all outputs 0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/sa_tile_if.sv
// Handshake and data bundle between a tile sequencer and its host/array.
// The master side drives the command and input vectors; the slave is the sequencer.
interface sa_tile_if #(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int INWIDTH = 8,
    parameter int KW      = 16
);
    localparam int DCW = (COLS > 1) ? $clog2(COLS) : 1;

    logic                            start;
    logic                            abort;
    logic [KW-1:0]                   cfg_k;
    logic                            in_valid;
    logic                            in_ready;
    logic [ROWS-1:0][INWIDTH-1:0]    a_in;
    logic [COLS-1:0][INWIDTH-1:0]    w_in;
    logic [ROWS-1:0][INWIDTH-1:0]    a_skew;
    logic [COLS-1:0][INWIDTH-1:0]    w_skew;
    logic                            arr_fire;
    logic                            acc_clr;
    logic                            out_valid;
    logic                            out_ready;
    logic [DCW-1:0]                  drain_col;
    logic                            done;
    logic                            err;
    logic                            busy;

    modport master (
        output start, abort, cfg_k, in_valid, a_in, w_in, out_ready,
        input  in_ready, a_skew, w_skew, arr_fire, acc_clr, out_valid,
               drain_col, done, err, busy
    );

    modport slave (
        input  start, abort, cfg_k, in_valid, a_in, w_in, out_ready,
        output in_ready, a_skew, w_skew, arr_fire, acc_clr, out_valid,
               drain_col, done, err, busy
    );
endinterface

// File: rtl/sa_tile_sequencer.sv
// Sequences one systolic-array tile: load K skewed vectors, flush the wavefront,
// then drain the result columns one at a time.
//
// state | meaning
// IDLE  | waiting for start; bad cfg_k pulses err
// LOAD  | accepting K input vectors, each accept advances the skew chains
// FLUSH | ROWS+COLS-1 zero-injecting fires, then one gap cycle for arr_fire to settle
// DRAIN | handing out columns 0..COLS-1 on out_valid/out_ready
module sa_tile_sequencer #(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int INWIDTH = 8,
    parameter int KW      = 16
) (
    input  logic    clk,
    input  logic    rstn,
    sa_tile_if.slave bus
);
    localparam int DCW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int FLN = ROWS + COLS - 1;
    localparam int FCW = $clog2(FLN + 1);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t         state;
    logic [KW-1:0]  k_rem;
    logic [FCW-1:0] fl_rem;
    logic [DCW-1:0] drain_col_q;
    logic           arr_fire_q;
    logic           acc_clr_q;
    logic           done_q;
    logic           err_q;

    logic accept;
    logic fire;
    logic load_phase;

    assign load_phase = (state == LOAD);
    assign accept     = load_phase && bus.in_valid;
    assign fire       = accept || ((state == FLUSH) && (fl_rem != '0));

    assign bus.in_ready  = load_phase;
    assign bus.out_valid = (state == DRAIN);
    assign bus.busy      = (state != IDLE);
    assign bus.arr_fire  = arr_fire_q;
    assign bus.acc_clr   = acc_clr_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.drain_col = drain_col_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            k_rem       <= '0;
            fl_rem      <= '0;
            drain_col_q <= '0;
            arr_fire_q  <= 1'b0;
            acc_clr_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            acc_clr_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            if (bus.abort) begin
                state       <= IDLE;
                k_rem       <= '0;
                fl_rem      <= '0;
                drain_col_q <= '0;
                arr_fire_q  <= 1'b0;
            end else begin
                arr_fire_q <= fire;
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            if (bus.cfg_k != '0) begin
                                state     <= LOAD;
                                k_rem     <= bus.cfg_k;
                                acc_clr_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        if (accept) begin
                            k_rem <= k_rem - KW'(1);
                            if (k_rem == KW'(1)) begin
                                state  <= FLUSH;
                                fl_rem <= FCW'(FLN);
                            end
                        end
                    end
                    FLUSH: begin
                        // terminal count reached: this cycle is the no-fire gap
                        if (fl_rem != '0) begin
                            fl_rem <= fl_rem - FCW'(1);
                        end else begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (bus.out_ready) begin
                            if (drain_col_q == DCW'(COLS - 1)) begin
                                state       <= IDLE;
                                drain_col_q <= '0;
                                done_q      <= 1'b1;
                            end else begin
                                drain_col_q <= drain_col_q + DCW'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Lane r of A gets r+1 stages so row r sees its data r cycles after row 0.
    for (genvar r = 0; r < ROWS; r++) begin : g_a
        logic [INWIDTH-1:0] stg [r+1];
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int j = 0; j <= r; j++) stg[j] <= '0;
            end else if (bus.abort) begin
                for (int j = 0; j <= r; j++) stg[j] <= '0;
            end else if (fire) begin
                stg[0] <= load_phase ? bus.a_in[r] : '0;
                for (int j = 1; j <= r; j++) stg[j] <= stg[j-1];
            end
        end
        assign bus.a_skew[r] = stg[r];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_w
        logic [INWIDTH-1:0] stg [c+1];
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int j = 0; j <= c; j++) stg[j] <= '0;
            end else if (bus.abort) begin
                for (int j = 0; j <= c; j++) stg[j] <= '0;
            end else if (fire) begin
                stg[0] <= load_phase ? bus.w_in[c] : '0;
                for (int j = 1; j <= c; j++) stg[j] <= stg[j-1];
            end
        end
        assign bus.w_skew[c] = stg[c];
    end
endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Directed bench for sa_tile_sequencer on a 4x4 array with a 4-bit K config.
module tb_sa_tile_sequencer;
    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int INWIDTH = 8;
    localparam int KW      = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    sa_tile_if #(.ROWS(ROWS), .COLS(COLS), .INWIDTH(INWIDTH), .KW(KW)) bus ();

    sa_tile_sequencer #(.ROWS(ROWS), .COLS(COLS), .INWIDTH(INWIDTH), .KW(KW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int fire_cnt = 0;
    int done_cnt = 0;
    int clr_cnt  = 0;
    logic [INWIDTH-1:0] a3_log [$];
    logic [INWIDTH-1:0] w0_log [$];

    always @(negedge clk) begin
        if (bus.arr_fire) begin
            fire_cnt++;
            a3_log.push_back(bus.a_skew[3]);
            w0_log.push_back(bus.w_skew[0]);
        end
        if (bus.done)    done_cnt++;
        if (bus.acc_clr) clr_cnt++;
    end

    int exp_a3 [10] = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 0};
    int exp_w0 [10] = '{8'h11, 8'h12, 8'h13, 0, 0, 0, 0, 0, 0, 0};
    int pat    [6]  = '{1, 0, 0, 1, 1, 1};
    int exp_dc [6]  = '{0, 1, 1, 1, 2, 3};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input logic [INWIDTH-1:0] v);
        for (int r = 0; r < ROWS; r++) bus.a_in[r] = v;
        for (int c = 0; c < COLS; c++) bus.w_in[c] = v + 8'h10;
    endtask

    task automatic start_tile(input logic [KW-1:0] k);
        bus.cfg_k = k;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40 && !bus.out_valid; i++) step();
        check_val(tag, {31'd0, bus.out_valid}, 32'd1);
    endtask

    task automatic drain_all(input string tag);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.done) break;
        end
        check_val(tag, {31'd0, bus.done}, 32'd1);
        bus.out_ready = 1'b0;
        step();
    endtask

    task automatic check_logs(input string tag, input int base);
        check_val({tag, "_n"}, a3_log.size() - base, 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (base + i < a3_log.size()) begin
                check_val($sformatf("%s_a3_%0d", tag, i), {24'd0, a3_log[base+i]}, exp_a3[i]);
                check_val($sformatf("%s_w0_%0d", tag, i), {24'd0, w0_log[base+i]}, exp_w0[i]);
            end
        end
    endtask

    initial begin
        int f0;
        int base;
        int c0;
        int d0;

        rstn          = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.cfg_k     = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_vec(8'd0);
        step();
        step();
        check_val("rst_busy",     {31'd0, bus.busy},      32'd0);
        check_val("rst_in_ready", {31'd0, bus.in_ready},  32'd0);
        check_val("rst_arr_fire", {31'd0, bus.arr_fire},  32'd0);
        check_val("rst_out_valid",{31'd0, bus.out_valid}, 32'd0);
        check_val("rst_flags",    {29'd0, bus.done, bus.err, bus.acc_clr}, 32'd0);
        check_val("rst_drain_col",{30'd0, bus.drain_col}, 32'd0);
        check_val("rst_a_skew",   bus.a_skew,             32'd0);
        check_val("rst_w_skew",   bus.w_skew,             32'd0);
        rstn = 1'b1;
        step();

        // Tile 1: K=3, continuous in_valid, then out_ready pattern in DRAIN
        f0 = fire_cnt; base = a3_log.size(); c0 = clr_cnt;
        set_vec(8'd1);
        bus.in_valid = 1'b1;
        start_tile(4'd3);
        check_val("t1_acc_clr",  {31'd0, bus.acc_clr},  32'd1);
        check_val("t1_in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        check_val("t1_fire1", {31'd0, bus.arr_fire}, 32'd1);
        set_vec(8'd2);
        step();
        set_vec(8'd3);
        step();
        check_val("t1_flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0;
        set_vec(8'd0);
        wait_drain("t1_drain_timeout");
        check_val("t1_drain_gap", {31'd0, bus.arr_fire}, 32'd0);
        check_val("t1_fire_cnt", fire_cnt - f0, 32'd10);
        check_val("t1_clr_cnt",  clr_cnt - c0,  32'd1);
        check_logs("t1", base);
        for (int i = 0; i < 6; i++) begin
            bus.out_ready = pat[i][0];
            check_val($sformatf("t1_dc_%0d", i), {30'd0, bus.drain_col}, exp_dc[i]);
            check_val($sformatf("t1_ov_%0d", i), {31'd0, bus.out_valid}, 32'd1);
            step();
        end
        bus.out_ready = 1'b0;
        check_val("t1_done", {31'd0, bus.done}, 32'd1);
        check_val("t1_busy_fall", {31'd0, bus.busy}, 32'd0);
        step();
        check_val("t1_done_pulse", {31'd0, bus.done}, 32'd0);
        check_val("t1_ov_drop",    {31'd0, bus.out_valid}, 32'd0);

        // Tile 2: stall two cycles after the first accept
        f0 = fire_cnt; base = a3_log.size();
        set_vec(8'd1);
        start_tile(4'd3);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        set_vec(8'd9);
        step();
        check_val("t2_stall_fire0", {31'd0, bus.arr_fire}, 32'd0);
        check_val("t2_stall_a0",    {24'd0, bus.a_skew[0]}, 32'd1);
        step();
        check_val("t2_stall_fire1", {31'd0, bus.arr_fire}, 32'd0);
        check_val("t2_stall_w0",    {24'd0, bus.w_skew[0]}, 32'h11);
        bus.in_valid = 1'b1;
        set_vec(8'd2);
        step();
        set_vec(8'd3);
        step();
        bus.in_valid = 1'b0;
        wait_drain("t2_drain_timeout");
        check_val("t2_fire_cnt", fire_cnt - f0, 32'd10);
        check_logs("t2", base);
        drain_all("t2_done");

        // Bad config, then start while busy
        start_tile(4'd0);
        check_val("t3_err",     {31'd0, bus.err},     32'd1);
        check_val("t3_busy",    {31'd0, bus.busy},    32'd0);
        check_val("t3_acc_clr", {31'd0, bus.acc_clr}, 32'd0);
        step();
        check_val("t3_err_pulse", {31'd0, bus.err}, 32'd0);
        start_tile(4'd2);
        check_val("t3_busy_load", {31'd0, bus.busy}, 32'd1);
        start_tile(4'd5);
        check_val("t3_busy_err",  {31'd0, bus.err},     32'd0);
        check_val("t3_busy_clr",  {31'd0, bus.acc_clr}, 32'd0);
        bus.in_valid = 1'b1;
        set_vec(8'd4);
        step();
        step();
        check_val("t3_k_kept", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0;
        wait_drain("t3_drain_timeout");
        drain_all("t3_done");

        // Abort in the second FLUSH cycle, then a normal K=1 tile
        d0 = done_cnt;
        bus.in_valid = 1'b1;
        set_vec(8'd5);
        start_tile(4'd2);
        step();
        step();
        bus.in_valid = 1'b0;
        step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check_val("t4_abort_busy",   {31'd0, bus.busy},     32'd0);
        check_val("t4_abort_a_skew", bus.a_skew,            32'd0);
        check_val("t4_abort_w_skew", bus.w_skew,            32'd0);
        check_val("t4_abort_fire",   {31'd0, bus.arr_fire}, 32'd0);
        repeat (3) step();
        check_val("t4_no_done", done_cnt - d0, 32'd0);
        f0 = fire_cnt;
        bus.in_valid = 1'b1;
        set_vec(8'd6);
        start_tile(4'd1);
        step();
        bus.in_valid = 1'b0;
        wait_drain("t4_drain_timeout");
        check_val("t4_fire_cnt", fire_cnt - f0, 32'd8);
        drain_all("t4_done");

        // Largest legal K for a 4-bit config
        f0 = fire_cnt;
        bus.in_valid = 1'b1;
        start_tile(4'd15);
        repeat (15) step();
        bus.in_valid = 1'b0;
        check_val("t5_in_ready", {31'd0, bus.in_ready}, 32'd0);
        wait_drain("t5_drain_timeout");
        check_val("t5_fire_cnt", fire_cnt - f0, 32'd22);
        drain_all("t5_done");

        // Reset in the middle of DRAIN
        bus.in_valid = 1'b1;
        start_tile(4'd1);
        step();
        bus.in_valid = 1'b0;
        wait_drain("t6_drain_timeout");
        bus.out_ready = 1'b1;
        step();
        step();
        bus.out_ready = 1'b0;
        check_val("t6_dc_before", {30'd0, bus.drain_col}, 32'd2);
        #2;
        rstn = 1'b0;
        #1;
        check_val("t6_rst_ov",   {31'd0, bus.out_valid}, 32'd0);
        check_val("t6_rst_dc",   {30'd0, bus.drain_col}, 32'd0);
        check_val("t6_rst_busy", {31'd0, bus.busy},      32'd0);
        check_val("t6_rst_flags",{29'd0, bus.done, bus.err, bus.acc_clr}, 32'd0);
        step();
        rstn = 1'b1;
        step();
        check_val("t6_idle", {31'd0, bus.busy}, 32'd0);
        f0 = fire_cnt;
        bus.in_valid = 1'b1;
        set_vec(8'd7);
        start_tile(4'd1);
        check_val("t6_acc_clr", {31'd0, bus.acc_clr}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        wait_drain("t6_post_drain_timeout");
        check_val("t6_fire_cnt", fire_cnt - f0, 32'd8);
        drain_all("t6_done");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
